divider_seq_n: RTL and testbench
================================

// Module: divider_seq_n
// PURPOSE
//  Parametrised multi-cycle integer divider for the datapath DIV/REM path.
//  Radix-2 restoring division with start/busy/done handshake and run-time signed/unsigned mode.
//  Defines results for divide-by-zero and signed overflow.
//  Sits behind the ALU result mux; the control unit holds the op in its stall state until out_done.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4); iteration count = WIDTH
// PORTS
//  clk              in   1      rising-edge clock
//  in_reset_n       in   1      asynchronous, active-low reset
//  in_start         in   1      request; sampled only in IDLE
//  in_signed        in   1      1 = two's-complement operands, 0 = unsigned; sampled with in_start
//  in_dividend      in   WIDTH  dividend; sampled with in_start
//  in_divisor       in   WIDTH  divisor; sampled with in_start
//  out_busy         out  1      high while an operation is in progress (state != IDLE)
//  out_done         out  1      one-cycle pulse; results valid from this cycle on
//  out_quotient     out  WIDTH  quotient (registered, held until next out_done)
//  out_remainder    out  WIDTH  remainder (registered, held until next out_done)
//  out_div_by_zero  out  1      divisor was 0 (registered with results, held)
// BEHAVIOUR
//  Reset: in_reset_n low clears immediately: state=IDLE, counter=0.
//   All outputs and internal A/Q/M regs are 0; no out_done.
//   Mid-operation reset aborts the op; no partial result is ever presented.
//  FSM: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: on edge E with in_start=1, latch mode, sign flags, |dividend| into Q, |divisor| into M.
//    Set A=0, counter=WIDTH-1, go to RUN. In unsigned mode magnitudes are the raw operands.
//   RUN: each edge, {A,Q} <<= 1; T = A - M (WIDTH+1 bits).
//    If T is negative, Q[0]=0 and A is kept (restore); otherwise A=T and Q[0]=1.
//    Decrement counter; after the edge where counter==0 go to FIX (exactly WIDTH RUN edges).
//   FIX: on the next edge, register outputs, pulse out_done=1 for one cycle, go to IDLE.
//  Latency: start at edge E -> out_done high from edge E+WIDTH+1 for one cycle.
//   out_busy high from E until E+WIDTH+1 and low in the out_done cycle. Fixed, data-independent.
//  Handshake:
//   - in_start while busy is ignored.
//   - Operand changes after E are ignored.
//   - in_start during the out_done cycle is accepted (back-to-back; FSM is IDLE).
//  Sign rules: quotient truncates toward zero.
//   Quotient is negated iff signed mode and the dividend and divisor signs differ.
//   Remainder takes the dividend's sign (dividend = q*divisor + r).
//  Divisor == 0 (either mode): out_quotient = all ones and out_remainder = in_dividend as captured.
//   out_div_by_zero=1. Full latency still applies.
//  Signed MIN / -1: out_quotient = MIN (1<<WIDTH-1), out_remainder = 0, no flag.
//   This falls out of magnitude arithmetic using WIDTH-bit unsigned |MIN|.
//  out_div_by_zero is cleared at the next out_done with a nonzero divisor.
// TESTING  (WIDTH=32 unless noted; check out_done exactly 33 cycles after start edge)
//  1 unsigned 0x1E/0x4 -> q=0x7, r=0x2, dbz=0; busy high 33 cycles, done one pulse
//  2 signed:
//     0xA / 0xFFFFFFFD            -> q=0xFFFFFFFD, r=0x1
//     0xFFFFFE0C / 0x3            -> q=0xFFFFFF5A, r=0xFFFFFFFE
//     0xFFFFFF9C / 0xFFFFFFF7     -> q=0xB, r=0xFFFFFFFF
//  3 edges:
//     unsigned 0xFFFFFFFF / 1     -> q=0xFFFFFFFF, r=0
//     signed   0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, dbz=0
//     unsigned 0x80000000 / 0xFFFFFFFF -> q=0, r=0x80000000
//  4 0x12345678 / 0 (signed and unsigned) -> q=0xFFFFFFFF, r=0x12345678, dbz=1
//     next op 9/3                 -> q=3, r=0, dbz=0
//  5 handshake:
//     pulse start + change operands mid-RUN -> ignored; result of first op unchanged
//     start in done cycle         -> second result 33 cycles later
//  6 reset:
//     in_reset_n low at RUN cycle 10 -> busy/done/outputs 0 asynchronously, no done after release
//     new op 100/7                -> q=14, r=2
//     WIDTH=8, signed 0x81/0x07   -> q=0xEE, r=0xFF

Source files
------------

// File: rtl/divider_seq_n_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// The master (control unit or bench) drives operands; the slave (divider) returns results.
interface divider_seq_n_if #(
  parameter int WIDTH = 32
);
  logic             in_start;
  logic             in_signed;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             out_busy;
  logic             out_done;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             out_div_by_zero;

  modport master (
    output in_start, in_signed, in_dividend, in_divisor,
    input  out_busy, out_done, out_quotient, out_remainder, out_div_by_zero
  );

  modport slave (
    input  in_start, in_signed, in_dividend, in_divisor,
    output out_busy, out_done, out_quotient, out_remainder, out_div_by_zero
  );
endinterface

// File: rtl/divider_seq_n.sv
// Radix-2 restoring divider, WIDTH iterations, fixed data-independent latency.
// Signed operands are reduced to magnitudes up front; signs are reapplied in FIX.
module divider_seq_n #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            in_reset_n,
  divider_seq_n_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_a;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] div_m;
  logic [WIDTH-1:0] dividend_raw;
  logic             neg_q;
  logic             neg_r;
  logic             zero_div;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  logic             accept;

  // Operand magnitudes; MIN stays 1<<(WIDTH-1), which is its correct unsigned magnitude.
  assign dividend_mag = (bus.in_signed && bus.in_dividend[WIDTH-1]) ? (~bus.in_dividend + 1'b1)
                                                                    : bus.in_dividend;
  assign divisor_mag  = (bus.in_signed && bus.in_divisor[WIDTH-1])  ? (~bus.in_divisor + 1'b1)
                                                                    : bus.in_divisor;

  // One restoring step: partial remainder is shifted one bit wider so 2A+1 never overflows.
  assign rem_shift = {acc_a, acc_q[WIDTH-1]};
  assign trial     = {1'b0, rem_shift} - {2'b00, div_m};
  assign accept    = (state == IDLE) && bus.in_start;

  assign bus.out_busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) state <= IDLE;
    else             state <= state_next;
  end

  // Next-state: IDLE -> RUN on start, RUN for WIDTH edges, one FIX edge, back to IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_start) state_next = RUN;
      RUN:     if (count == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registration with sign/zero fixup.
  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      count               <= '0;
      acc_a               <= '0;
      acc_q               <= '0;
      div_m               <= '0;
      dividend_raw        <= '0;
      neg_q               <= 1'b0;
      neg_r               <= 1'b0;
      zero_div            <= 1'b0;
      bus.out_done        <= 1'b0;
      bus.out_quotient    <= '0;
      bus.out_remainder   <= '0;
      bus.out_div_by_zero <= 1'b0;
    end else begin
      bus.out_done <= 1'b0;
      if (accept) begin
        count        <= CW'(WIDTH - 1);
        acc_a        <= '0;
        acc_q        <= dividend_mag;
        div_m        <= divisor_mag;
        dividend_raw <= bus.in_dividend;
        neg_q        <= bus.in_signed && (bus.in_dividend[WIDTH-1] ^ bus.in_divisor[WIDTH-1]);
        neg_r        <= bus.in_signed && bus.in_dividend[WIDTH-1];
        zero_div     <= (bus.in_divisor == '0);
      end else if (state == RUN) begin
        count <= count - 1'b1;
        if (trial[WIDTH+1]) begin
          acc_a <= rem_shift[WIDTH-1:0];
          acc_q <= {acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_a <= trial[WIDTH-1:0];
          acc_q <= {acc_q[WIDTH-2:0], 1'b1};
        end
      end else if (state == FIX) begin
        bus.out_done        <= 1'b1;
        bus.out_div_by_zero <= zero_div;
        if (zero_div) begin
          bus.out_quotient  <= '1;
          bus.out_remainder <= dividend_raw;
        end else begin
          bus.out_quotient  <= neg_q ? (~acc_q + 1'b1) : acc_q;
          bus.out_remainder <= neg_r ? (~acc_a + 1'b1) : acc_a;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_seq_n.sv
// Directed bench for divider_seq_n: 32-bit instance for most cases, 8-bit instance for the narrow signed case.
module tb_divider_seq_n;

  logic clk;
  logic in_reset_n;
  int   checks;
  int   errors;

  divider_seq_n_if #(.WIDTH(32)) bus32 ();
  divider_seq_n_if #(.WIDTH(8))  bus8  ();

  divider_seq_n #(.WIDTH(32)) dut (
    .clk        (clk),
    .in_reset_n (in_reset_n),
    .bus        (bus32.slave)
  );

  divider_seq_n #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .in_reset_n (in_reset_n),
    .bus        (bus8.slave)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives operands now and lets the next rising edge be the start edge; returns 1 ns after it.
  task automatic applyStimulus(input logic sgn, input logic [31:0] dvd, input logic [31:0] dvs);
    bus32.in_signed   = sgn;
    bus32.in_dividend = dvd;
    bus32.in_divisor  = dvs;
    bus32.in_start    = 1'b1;
    @(posedge clk);
    #1;
    bus32.in_start = 1'b0;
    checkOutput("busy_after_start", {31'b0, bus32.out_busy}, 32'h1);
  endtask

  // Waits (bounded) for out_done; 'elapsed' cycles since the start edge have already passed.
  task automatic waitDone(input string tag, input int elapsed);
    int done_cycle;
    int busy_cycles;
    done_cycle  = -1;
    busy_cycles = 0;
    for (int cyc = elapsed + 1; cyc <= 45 && done_cycle < 0; cyc++) begin
      @(posedge clk);
      #1;
      if (bus32.out_done) begin
        done_cycle = cyc;
        checkOutput({tag, "_busy_in_done"}, {31'b0, bus32.out_busy}, 32'h0);
      end else if (bus32.out_busy) begin
        busy_cycles++;
      end
    end
    checkOutput({tag, "_latency"}, done_cycle, 32'd33);
    checkOutput({tag, "_busy_cycles"}, busy_cycles, 32'd32 - elapsed);
  endtask

  task automatic checkResult(input string tag, input logic [31:0] q, input logic [31:0] r, input logic z);
    checkOutput({tag, "_q"},   bus32.out_quotient, q);
    checkOutput({tag, "_r"},   bus32.out_remainder, r);
    checkOutput({tag, "_dbz"}, {31'b0, bus32.out_div_by_zero}, {31'b0, z});
  endtask

  // Whole directed sequence.
  initial begin
    int done_seen;
    int done8_cycle;
    checks = 0;
    errors = 0;
    in_reset_n        = 1'b0;
    bus32.in_start    = 1'b0;
    bus32.in_signed   = 1'b0;
    bus32.in_dividend = '0;
    bus32.in_divisor  = '0;
    bus8.in_start     = 1'b0;
    bus8.in_signed    = 1'b0;
    bus8.in_dividend  = '0;
    bus8.in_divisor   = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'b0, bus32.out_busy}, 32'h0);
    checkOutput("reset_done", {31'b0, bus32.out_done}, 32'h0);
    checkResult("reset", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    in_reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] unsigned basic");
    applyStimulus(1'b0, 32'h1E, 32'h4);
    waitDone("u_30_4", 0);
    checkResult("u_30_4", 32'h7, 32'h2, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("done_one_pulse", {31'b0, bus32.out_done}, 32'h0);
    checkOutput("q_held", bus32.out_quotient, 32'h7);

    $display("[TB] signed");
    applyStimulus(1'b1, 32'h0000000A, 32'hFFFFFFFD);
    waitDone("s_10_m3", 0);
    checkResult("s_10_m3", 32'hFFFFFFFD, 32'h1, 1'b0);
    applyStimulus(1'b1, 32'hFFFFFE0C, 32'h3);
    waitDone("s_m500_3", 0);
    checkResult("s_m500_3", 32'hFFFFFF5A, 32'hFFFFFFFE, 1'b0);
    applyStimulus(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF7);
    waitDone("s_m100_m9", 0);
    checkResult("s_m100_m9", 32'hB, 32'hFFFFFFFF, 1'b0);

    $display("[TB] edge operands");
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'h1);
    waitDone("u_max_1", 0);
    checkResult("u_max_1", 32'hFFFFFFFF, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF);
    waitDone("s_min_m1", 0);
    checkResult("s_min_m1", 32'h80000000, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h80000000, 32'hFFFFFFFF);
    waitDone("u_min_max", 0);
    checkResult("u_min_max", 32'h0, 32'h80000000, 1'b0);

    $display("[TB] divide by zero");
    applyStimulus(1'b1, 32'h12345678, 32'h0);
    waitDone("s_dbz", 0);
    checkResult("s_dbz", 32'hFFFFFFFF, 32'h12345678, 1'b1);
    applyStimulus(1'b0, 32'h12345678, 32'h0);
    waitDone("u_dbz", 0);
    checkResult("u_dbz", 32'hFFFFFFFF, 32'h12345678, 1'b1);
    applyStimulus(1'b0, 32'h9, 32'h3);
    waitDone("after_dbz", 0);
    checkResult("after_dbz", 32'h3, 32'h0, 1'b0);

    $display("[TB] handshake");
    applyStimulus(1'b0, 32'd1000, 32'd7);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    bus32.in_start    = 1'b1;
    bus32.in_dividend = 32'd50;
    bus32.in_divisor  = 32'd5;
    @(posedge clk);
    #1;
    bus32.in_start = 1'b0;
    waitDone("ignored_start", 6);
    checkResult("ignored_start", 32'd142, 32'd6, 1'b0);
    applyStimulus(1'b0, 32'd77, 32'd10);
    waitDone("back_to_back", 0);
    checkResult("back_to_back", 32'd7, 32'd7, 1'b0);

    $display("[TB] async reset mid-run");
    applyStimulus(1'b0, 32'd500, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    #2;
    in_reset_n = 1'b0;
    #1;
    checkOutput("rst_busy", {31'b0, bus32.out_busy}, 32'h0);
    checkOutput("rst_done", {31'b0, bus32.out_done}, 32'h0);
    checkResult("rst", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    in_reset_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus32.out_done) done_seen++;
    end
    checkOutput("no_done_after_rst", done_seen, 32'd0);
    applyStimulus(1'b0, 32'd100, 32'd7);
    waitDone("post_rst", 0);
    checkResult("post_rst", 32'd14, 32'd2, 1'b0);

    $display("[TB] width 8 signed");
    @(negedge clk);
    bus8.in_signed   = 1'b1;
    bus8.in_dividend = 8'h81;
    bus8.in_divisor  = 8'h07;
    bus8.in_start    = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_start = 1'b0;
    done8_cycle = -1;
    for (int cyc = 1; cyc <= 20 && done8_cycle < 0; cyc++) begin
      @(posedge clk);
      #1;
      if (bus8.out_done) done8_cycle = cyc;
    end
    checkOutput("w8_latency", done8_cycle, 32'd9);
    checkOutput("w8_q", {24'b0, bus8.out_quotient}, 32'hEE);
    checkOutput("w8_r", {24'b0, bus8.out_remainder}, 32'hFF);
    checkOutput("w8_dbz", {31'b0, bus8.out_div_by_zero}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
